matvec_seq: RTL and testbench

- Sequencer that drives a VSIZE-wide float dot-product unit as its requesting initiator.
- Loads a vector x serially, then streams n_rows matrix rows. Each row is issued with x to the dot-product unit, and the scalar result y[r] is returned on an output stream.
- Sits between the AXI-lite/DMA-side word streams and the dot-product datapath, forming a matrix-vector multiply engine.

---
 rtl/matvec_seq.sv | 217 +++++++++++++++++++++
 tb/tb_matvec_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_seq.sv
// -----------------------------------------------------------------------------
// matvec_seq -- matrix-vector multiply sequencer.
//
// Loads a VSIZE-word vector x from the x stream, then for each of n_rows
// matrix rows loads the row from the a stream, issues row and x to an external
// fixed-latency dot-product unit, and returns the scalar result on the y
// stream. Only one dot product is ever in flight; completion is detected by
// counting DP_LAT cycles from the issue edge.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, n_rows         job request (n_rows sampled on start, 0 = empty job)
//   x_data/valid/ready    x word stream, word 0 first
//   a_data/valid/ready    matrix row words, row-major, word 0 first
//   dp_in1, dp_in2        row / x operands, lane i = word i
//   dp_en                 one-cycle issue strobe
//   dp_result             dot-product result, valid DP_LAT cycles after issue
//   y_data/valid/ready    result stream
//   busy, done            job status; done pulses once at job end
//
// Optional feature (macro MATVEC_SEQ_PERF_EN):
//   perf_cycles           cycles from start accept to done inclusive
//   perf_stall            cycles spent in OUT with y_ready low
// -----------------------------------------------------------------------------
module matvec_seq #(
    parameter int VSIZE  = 4,
    parameter int DP_LAT = 8,
    parameter int ROW_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ROW_W-1:0]      n_rows,
    input  logic [31:0]           x_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [31:0]           a_data,
    input  logic                  a_valid,
    output logic                  a_ready,
    output logic [VSIZE*32-1:0]   dp_in1,
    output logic [VSIZE*32-1:0]   dp_in2,
    output logic                  dp_en,
    input  logic [31:0]           dp_result,
    output logic [31:0]           y_data,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic                  busy,
    output logic                  done
`ifdef MATVEC_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stall
`endif
);

    localparam int WCNT_W = (VSIZE > 1) ? $clog2(VSIZE) : 1;
    localparam int LAT_W  = $clog2(DP_LAT) + 1;
    localparam logic [WCNT_W-1:0] WLAST    = WCNT_W'(VSIZE - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(DP_LAT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_X   = 3'd1,
        LOAD_ROW = 3'd2,
        ISSUE    = 3'd3,
        WAIT     = 3'd4,
        OUT      = 3'd5,
        FIN      = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [ROW_W-1:0]    rcnt_q;
    logic [ROW_W-1:0]    nrows_q;
    logic [LAT_W-1:0]    lat_q;
    logic [31:0]         xbuf [VSIZE];
    logic [31:0]         rbuf [VSIZE];
    logic [31:0]         y_data_q;
    logic                last_row;

    // One bit wider than rcnt so n_rows = 2^ROW_W-1 terminates without wrap.
    assign last_row = (({1'b0, rcnt_q} + (ROW_W+1)'(1)) == {1'b0, nrows_q});

    // Next-state and decoded outputs
    always_comb begin
        state_d = state_q;
        x_ready = 1'b0;
        a_ready = 1'b0;
        dp_en   = 1'b0;
        y_valid = 1'b0;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (n_rows != '0) ? LOAD_X : FIN;
            end
            LOAD_X: begin
                x_ready = 1'b1;
                if (x_valid && wcnt_q == WLAST) state_d = LOAD_ROW;
            end
            LOAD_ROW: begin
                a_ready = 1'b1;
                if (a_valid && wcnt_q == WLAST) state_d = ISSUE;
            end
            ISSUE: begin
                dp_en   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == '0) state_d = OUT;
            end
            OUT: begin
                y_valid = 1'b1;
                if (y_ready) state_d = last_row ? FIN : LOAD_ROW;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand buses are wired straight from the buffers; the buffers are not
    // written between ISSUE and the next LOAD_ROW, so the operands hold.
    always_comb begin
        dp_in1 = '0;
        dp_in2 = '0;
        for (int i = 0; i < VSIZE; i++) begin
            dp_in1[i*32 +: 32] = rbuf[i];
            dp_in2[i*32 +: 32] = xbuf[i];
        end
    end

    assign y_data = y_data_q;

    // State, counters and buffers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            nrows_q  <= '0;
            lat_q    <= '0;
            y_data_q <= '0;
            for (int i = 0; i < VSIZE; i++) begin
                xbuf[i] <= '0;
                rbuf[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        nrows_q <= n_rows;
                        wcnt_q  <= '0;
                        rcnt_q  <= '0;
                    end
                end
                LOAD_X: begin
                    if (x_valid) begin
                        xbuf[wcnt_q] <= x_data;
                        wcnt_q       <= (wcnt_q == WLAST) ? '0 : wcnt_q + 1'b1;
                    end
                end
                LOAD_ROW: begin
                    if (a_valid) begin
                        rbuf[wcnt_q] <= a_data;
                        wcnt_q       <= (wcnt_q == WLAST) ? '0 : wcnt_q + 1'b1;
                    end
                end
                ISSUE: begin
                    lat_q <= LAT_INIT;
                end
                WAIT: begin
                    // Capture lands exactly DP_LAT edges after the issue edge.
                    if (lat_q == '0) y_data_q <= dp_result;
                    else             lat_q    <= lat_q - 1'b1;
                end
                OUT: begin
                    if (y_ready) rcnt_q <= rcnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MATVEC_SEQ_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stall_q;

    // The start cycle counts as cycle 1; every busy cycle up to and including
    // FIN adds one. Values hold in IDLE until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if (state_q == IDLE && start) begin
            perf_cycles_q <= 32'd1;
            perf_stall_q  <= '0;
        end else begin
            if (state_q != IDLE)
                perf_cycles_q <= sat_inc(perf_cycles_q);
            if (state_q == OUT && !y_ready)
                perf_stall_q <= sat_inc(perf_stall_q);
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_matvec_seq.sv
module tb_matvec_seq;

    localparam int VSIZE  = 4;
    localparam int DP_LAT = 8;
    localparam int ROW_W  = 8;
    localparam int VW     = VSIZE * 32;

    typedef logic [31:0] word_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ROW_W-1:0]  n_rows = '0;
    logic [31:0]       x_data = '0;
    logic              x_valid = 1'b0;
    logic              x_ready;
    logic [31:0]       a_data = '0;
    logic              a_valid = 1'b0;
    logic              a_ready;
    logic [VW-1:0]     dp_in1;
    logic [VW-1:0]     dp_in2;
    logic              dp_en;
    logic [31:0]       dp_result = 32'hDEADBEEF;
    logic [31:0]       y_data;
    logic              y_valid;
    logic              y_ready = 1'b0;
    logic              busy;
    logic              done;
`ifdef MATVEC_SEQ_PERF_EN
    logic [31:0]       perf_cycles;
    logic [31:0]       perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    matvec_seq #(.VSIZE(VSIZE), .DP_LAT(DP_LAT), .ROW_W(ROW_W)) dut (
        .clk(clk), .rst(rst), .start(start), .n_rows(n_rows),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_en(dp_en), .dp_result(dp_result),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
        .busy(busy), .done(done)
`ifdef MATVEC_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // IEEE754 single constants
    localparam word_t F0 = 32'h00000000;
    localparam word_t F1 = 32'h3F800000;
    localparam word_t F2 = 32'h40000000;
    localparam word_t F3 = 32'h40400000;
    localparam word_t F4 = 32'h40800000;

    word_t X1 [VSIZE] = '{F1, F2, F3, F4};
    word_t R0 [VSIZE] = '{F1, F1, F1, F1};   // . x = 10.0
    word_t R1 [VSIZE] = '{F0, F0, F0, F2};   // . x = 8.0
    word_t R2 [VSIZE] = '{F2, F0, F0, F0};   // . x = 2.0
    word_t R3 [VSIZE] = '{F0, F0, F1, F1};   // . x = 7.0
    word_t R4 [VSIZE] = '{F4, F3, F2, F1};   // . x = 20.0
    word_t R5 [VSIZE] = '{F0, F1, F0, F0};   // . x = 2.0

    // Edge counters and dot-product unit model. The model presents the queued
    // result only during the single cycle preceding edge issue+DP_LAT and
    // garbage otherwise, so an early or late capture shows up in y_data.
    int    edge_n = 0;
    int    issue_edge = -1000;
    int    done_cnt = 0, dp_en_cnt = 0, xhs_cnt = 0, ahs_cnt = 0, yhs_cnt = 0;
    word_t pend = 32'hDEADBEEF;
    word_t dp_q [$];

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (done) done_cnt++;
        if (x_valid && x_ready) xhs_cnt++;
        if (a_valid && a_ready) ahs_cnt++;
        if (y_valid && y_ready) yhs_cnt++;
        if (dp_en) begin
            dp_en_cnt++;
            issue_edge = edge_n;
            pend = (dp_q.size() > 0) ? dp_q.pop_front() : 32'hDEADBEEF;
        end
        dp_result <= (edge_n == issue_edge + DP_LAT - 1) ? pend : 32'hDEADBEEF;
    end

    function automatic logic [VW-1:0] pack(input word_t w [VSIZE]);
        logic [VW-1:0] p;
        for (int i = 0; i < VSIZE; i++) p[i*32 +: 32] = w[i];
        return p;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic pulse_start(input logic [ROW_W-1:0] n);
        @(negedge clk);
        start = 1'b1; n_rows = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_x(input word_t w [VSIZE], input bit gaps, output bit ok);
        int i = 0;
        int g = 0;
        bit hs;
        while (i < VSIZE && g < 200) begin
            x_data  = w[i];
            x_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = x_valid && x_ready;
            @(negedge clk);
            if (hs) i++;
            g++;
        end
        x_valid = 1'b0;
        ok = (i == VSIZE);
    endtask

    task automatic send_row(input word_t w [VSIZE], input bit gaps, output bit ok);
        int i = 0;
        int g = 0;
        bit hs;
        while (i < VSIZE && g < 200) begin
            a_data  = w[i];
            a_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = a_valid && a_ready;
            @(negedge clk);
            if (hs) i++;
            g++;
        end
        a_valid = 1'b0;
        ok = (i == VSIZE);
    endtask

    task automatic recv_y(input int hold, output word_t y, output logic [VW-1:0] in1,
                          output logic [VW-1:0] in2, output int lat,
                          output bit ok, output bit hold_ok);
        int g = 0;
        ok = 1'b0; hold_ok = 1'b1; y = '0; in1 = '0; in2 = '0; lat = -1;
        while (y_valid !== 1'b1 && g < DP_LAT + 20) begin
            @(negedge clk);
            g++;
        end
        if (y_valid === 1'b1) begin
            ok = 1'b1;
            y = y_data; in1 = dp_in1; in2 = dp_in2;
            lat = edge_n - issue_edge;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (y_valid !== 1'b1 || y_data !== y || a_ready !== 1'b0) hold_ok = 1'b0;
            end
            y_ready = 1'b1;
            @(negedge clk);
            y_ready = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if ({x_ready, a_ready, dp_en, y_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_ctl: got %b want 0000", {x_ready, a_ready, dp_en, y_valid}); end
        checks++; if (y_data !== 32'h0) begin errors++; $display("FAIL reset_y: got %h want 0", y_data); end
        checks++; if (dp_in1 !== '0 || dp_in2 !== '0) begin
            errors++; $display("FAIL reset_dp_in: got %h / %h want 0", dp_in1, dp_in2); end
    endtask

    task automatic test_basic();
        bit ok, hok; word_t y; logic [VW-1:0] i1, i2; int lat;
        int d0 = done_cnt, e0 = dp_en_cnt;
        dp_q.push_back(32'h41200000);
        dp_q.push_back(32'h41000000);
        pulse_start(8'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        send_x(X1, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_x_load: got timeout want %0d words", VSIZE); end
        send_row(R0, 1'b0, ok);
        recv_y(0, y, i1, i2, lat, ok, hok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_y0_timeout: got none want y_valid"); end
        checks++; if (y !== 32'h41200000) begin errors++; $display("FAIL basic_y0: got %h want 41200000", y); end
        checks++; if (lat != DP_LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, DP_LAT); end
        checks++; if (i1 !== pack(R0) || i2 !== pack(X1)) begin
            errors++; $display("FAIL basic_dp_in0: got %h / %h want %h / %h", i1, i2, pack(R0), pack(X1)); end
        send_row(R1, 1'b0, ok);
        recv_y(0, y, i1, i2, lat, ok, hok);
        checks++; if (y !== 32'h41000000) begin errors++; $display("FAIL basic_y1: got %h want 41000000", y); end
        checks++; if (i1 !== pack(R1)) begin errors++; $display("FAIL basic_dp_in1: got %h want %h", i1, pack(R1)); end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0); end
        checks++; if (dp_en_cnt - e0 != 2) begin errors++; $display("FAIL basic_issues: got %0d want 2", dp_en_cnt - e0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        bit ok, hok; word_t y; logic [VW-1:0] i1, i2; int lat;
        int y0 = yhs_cnt, a0;
        dp_q.push_back(32'h40000000);
        dp_q.push_back(32'h40E00000);
        pulse_start(8'd2);
        send_x(X1, 1'b0, ok);
        send_row(R2, 1'b0, ok);
        a_valid = 1'b1; a_data = 32'hBAD0BAD0;
        a0 = ahs_cnt;
        recv_y(5, y, i1, i2, lat, ok, hok);
        a_valid = 1'b0;
        checks++; if (!hok) begin errors++; $display("FAIL bp_hold: got unstable y/a_ready want stable"); end
        checks++; if (ahs_cnt != a0) begin errors++; $display("FAIL bp_a_consumed: got %0d want 0", ahs_cnt - a0); end
        checks++; if (y !== 32'h40000000) begin errors++; $display("FAIL bp_y0: got %h want 40000000", y); end
        send_row(R3, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_row1_load: got timeout want accepted"); end
        recv_y(2, y, i1, i2, lat, ok, hok);
        checks++; if (y !== 32'h40E00000 || i1 !== pack(R3)) begin
            errors++; $display("FAIL bp_y1: got %h / %h want 40e00000 / %h", y, i1, pack(R3)); end
        repeat (3) @(negedge clk);
        checks++; if (yhs_cnt - y0 != 2) begin errors++; $display("FAIL bp_rows: got %0d want 2", yhs_cnt - y0); end
    endtask

    task automatic test_empty();
        int d0 = done_cnt, x0 = xhs_cnt, a0 = ahs_cnt;
        int seen_at = -1;
        pulse_start(8'd0);
        for (int k = 0; k < 2; k++) begin
            if (done === 1'b1 && seen_at < 0) seen_at = k;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++; if (seen_at < 0) begin errors++; $display("FAIL empty_done_time: got none want pulse within 2 cycles"); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL empty_done_cnt: got %0d want 1", done_cnt - d0); end
        checks++; if (xhs_cnt != x0 || ahs_cnt != a0) begin
            errors++; $display("FAIL empty_handshakes: got %0d/%0d want 0/0", xhs_cnt - x0, ahs_cnt - a0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy: got %b want 0", busy); end
    endtask

    task automatic test_ignored_start();
        bit ok, hok; word_t y; logic [VW-1:0] i1, i2; int lat;
        int d0 = done_cnt, e0 = dp_en_cnt;
        dp_q.push_back(32'h41200000);
        dp_q.push_back(32'h41000000);
        pulse_start(8'd2);
        send_x(X1, 1'b0, ok);
        pulse_start(8'd7);
        send_row(R0, 1'b0, ok);
        recv_y(0, y, i1, i2, lat, ok, hok);
        checks++; if (y !== 32'h41200000) begin errors++; $display("FAIL ign_y0: got %h want 41200000", y); end
        send_row(R1, 1'b0, ok);
        recv_y(0, y, i1, i2, lat, ok, hok);
        checks++; if (y !== 32'h41000000) begin errors++; $display("FAIL ign_y1: got %h want 41000000", y); end
        repeat (20) @(negedge clk);
        checks++; if (done_cnt - d0 != 1 || dp_en_cnt - e0 != 2) begin
            errors++; $display("FAIL ign_job: got done=%0d issues=%0d want 1/2", done_cnt - d0, dp_en_cnt - e0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int d0 = done_cnt, y0 = yhs_cnt;
        dp_q.push_back(32'h41200000);
        pulse_start(8'd1);
        send_x(X1, 1'b0, ok);
        send_row(R0, 1'b0, ok);
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1 || dp_en !== 1'b0) begin
            errors++; $display("FAIL rmw_in_wait: got busy=%b dp_en=%b want 1/0", busy, dp_en); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({busy, done, x_ready, a_ready, dp_en, y_valid} !== 6'b0) begin
            errors++; $display("FAIL rmw_ctl: got %b want 000000", {busy, done, x_ready, a_ready, dp_en, y_valid}); end
        checks++; if (y_data !== 32'h0 || dp_in1 !== '0 || dp_in2 !== '0) begin
            errors++; $display("FAIL rmw_data: got y=%h in1=%h want 0", y_data, dp_in1); end
        repeat (15) @(negedge clk);
        checks++; if (done_cnt != d0 || yhs_cnt != y0) begin
            errors++; $display("FAIL rmw_no_done: got done=%0d y=%0d want 0/0", done_cnt - d0, yhs_cnt - y0); end
    endtask

    task automatic test_gaps();
        bit ok, hok; word_t y; logic [VW-1:0] i1, i2; int lat;
        dp_q.push_back(32'h41A00000);
        dp_q.push_back(32'h40000000);
        pulse_start(8'd2);
        send_x(X1, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL gaps_x_load: got timeout want accepted"); end
        send_row(R4, 1'b1, ok);
        recv_y(0, y, i1, i2, lat, ok, hok);
        checks++; if (i1 !== pack(R4) || i2 !== pack(X1)) begin
            errors++; $display("FAIL gaps_lanes0: got %h / %h want %h / %h", i1, i2, pack(R4), pack(X1)); end
        checks++; if (y !== 32'h41A00000) begin errors++; $display("FAIL gaps_y0: got %h want 41a00000", y); end
        send_row(R5, 1'b1, ok);
        recv_y(0, y, i1, i2, lat, ok, hok);
        checks++; if (i1 !== pack(R5) || y !== 32'h40000000) begin
            errors++; $display("FAIL gaps_row1: got %h / %h want %h / 40000000", i1, y, pack(R5)); end
        checks++; if (lat != DP_LAT) begin errors++; $display("FAIL gaps_latency: got %0d want %0d", lat, DP_LAT); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_max_rows();
        bit ok, hok; word_t y; logic [VW-1:0] i1, i2; int lat;
        int d0 = done_cnt, y0 = yhs_cnt;
        for (int r = 0; r < 255; r++) dp_q.push_back(32'h00001000 + r);
        pulse_start(8'd255);
        send_x(X1, 1'b0, ok);
        for (int r = 0; r < 255; r++) begin
            send_row(R0, 1'b0, ok);
            recv_y(0, y, i1, i2, lat, ok, hok);
            checks++;
            if (y !== 32'h00001000 + r) begin
                errors++; $display("FAIL max_row_%0d: got %h want %h", r, y, 32'h00001000 + r);
            end
        end
        repeat (3) @(negedge clk);
        checks++; if (yhs_cnt - y0 != 255 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL max_rows_end: got y=%0d done=%0d want 255/1", yhs_cnt - y0, done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL max_rows_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_ignored_start();
        test_reset_mid_wait();
        test_gaps();
        test_max_rows();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
